// File: rtl/syncfifo_drain_if.sv
// rtl/syncfifo_drain_if.sv - FIFO read port and output stream bundle for syncfifo_drain
// master: the drain controller; slave: the FIFO model plus the downstream consumer.
interface syncfifo_drain_if #(
    parameter int NBITS = 16
);
    logic             fifo_empty;
    logic [NBITS-1:0] fifo_q;
    logic             fifo_ren;
    logic             out_val;
    logic             out_rdy;
    logic [NBITS-1:0] out_msg;
    logic             out_last;

    modport master (
        input  fifo_empty,
        input  fifo_q,
        input  out_rdy,
        output fifo_ren,
        output out_val,
        output out_msg,
        output out_last
    );

    modport slave (
        output fifo_empty,
        output fifo_q,
        output out_rdy,
        input  fifo_ren,
        input  out_val,
        input  out_msg,
        input  out_last
    );
endinterface

// File: rtl/syncfifo_drain.sv
// rtl/syncfifo_drain.sv - SyncFIFO read-side drain with 2-entry skid buffer and frame marker
// Optional SYNCFIFO_DRAIN_BEATCNT_EN adds a saturating 32-bit pop counter on beat_cnt.
module syncfifo_drain #(
    parameter int NBITS     = 16,
    parameter int FRAME_LEN = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
`ifdef SYNCFIFO_DRAIN_BEATCNT_EN
    output logic [31:0] beat_cnt,
`endif
    syncfifo_drain_if.master bus
);
    localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CW-1:0] FCNT_LAST = CW'(FRAME_LEN - 1);

    logic [1:0]       occ_q, occ_d;
    logic [NBITS-1:0] head_q, head_d;
    logic [NBITS-1:0] skid_q, skid_d;
    logic [CW-1:0]    fcnt_q, fcnt_d;
    logic             push;
    logic             pop;

    // Reading is allowed whenever a slot is free now or the head leaves this cycle.
    assign bus.fifo_ren = rst_n & ~flush & ~bus.fifo_empty
                        & ((occ_q != 2'd2) | bus.out_rdy);
    assign bus.out_val  = (occ_q != 2'd0) & ~flush;
    assign bus.out_last = bus.out_val & (fcnt_q == FCNT_LAST);
    assign bus.out_msg  = head_q;

    assign push = bus.fifo_ren;
    assign pop  = bus.out_val & bus.out_rdy;

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        skid_d = skid_q;
        fcnt_d = fcnt_q;
        if (flush) begin
            occ_d  = 2'd0;
            fcnt_d = '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ_q == 2'd0) head_d = bus.fifo_q;
                    else               skid_d = bus.fifo_q;
                    occ_d = occ_q + 2'd1;
                end
                2'b01: begin
                    if (occ_q == 2'd2) head_d = skid_q;
                    occ_d = occ_q - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the queue just shifts by one.
                    if (occ_q == 2'd2) begin
                        head_d = skid_q;
                        skid_d = bus.fifo_q;
                    end else begin
                        head_d = bus.fifo_q;
                    end
                end
                default: ;
            endcase
            if (pop) fcnt_d = (fcnt_q == FCNT_LAST) ? '0 : fcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q  <= 2'd0;
            head_q <= '0;
            skid_q <= '0;
            fcnt_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            skid_q <= skid_d;
            fcnt_q <= fcnt_d;
        end
    end

`ifdef SYNCFIFO_DRAIN_BEATCNT_EN
    logic [31:0] beat_cnt_q;

    // Survives flush on purpose: it is a lifetime pop count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          beat_cnt_q <= '0;
        else if (pop && (beat_cnt_q != '1))  beat_cnt_q <= beat_cnt_q + 32'd1;
    end

    assign beat_cnt = beat_cnt_q;
`endif
endmodule
